tfg_twiddle_store: RTL and testbench

- Downstream consumer of FOF_TFG. Captures each o_valid beat of n parallel MAX_BW-bit twiddle factors into on-chip memory, counts beats against the NTT size, and signals when the table is complete.
- Then serves addressed, 1-cycle-latency reads to the NTT butterfly array.
- Decouples the one-shot generation burst from the repeated per-stage twiddle fetches.

---
 rtl/tfg_pkg.sv | 15 +
 rtl/tfg_buf_ram.sv | 37 +++
 rtl/tfg_twiddle_store.sv | 114 +++++++++++
 tb/tb_tfg_twiddle_store.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/tfg_pkg.sv
// Shared types and constants for the twiddle-factor store.
package tfg_pkg;

  typedef enum logic [1:0] {StIdle, StFill, StReady} state_e;

  localparam int unsigned TfgMaxBw = 62;
  localparam int unsigned TfgLanes = 16;

  // Lane k of a packed beat; lane 0 sits in the least significant bits.
  function automatic logic [TfgMaxBw-1:0] lane(input logic [TfgLanes*TfgMaxBw-1:0] beat,
                                               input int unsigned k);
    return beat[k*TfgMaxBw +: TfgMaxBw];
  endfunction

endpackage

// File: rtl/tfg_buf_ram.sv
// Simple dual-port beat buffer with a registered, resettable read port.
module tfg_buf_ram #(
  parameter int unsigned Width = 992,
  parameter int unsigned Depth = 2048,
  parameter int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en_i,
  input  logic [AddrW-1:0] wr_addr_i,
  input  logic [Width-1:0] wr_data_i,
  input  logic             rd_en_i,
  input  logic [AddrW-1:0] rd_addr_i,
  output logic [Width-1:0] rd_data_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Only the output register is reset; it holds when no read is accepted.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/tfg_twiddle_store.sv
// Captures a TFG burst into the beat buffer, then serves gated 1-cycle reads.
module tfg_twiddle_store
  import tfg_pkg::*;
#(
  parameter int unsigned MAX_BW = TfgMaxBw,
  parameter int unsigned n      = TfgLanes,
  parameter int unsigned DEPTH  = 2048,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  input  logic [3:0]          i_log2N,
  input  logic                i_valid,
  input  logic [n*MAX_BW-1:0] i_tfg,
  input  logic                i_rd_en,
  input  logic [ADDR_W-1:0]   i_rd_addr,
  output logic                o_rd_valid,
  output logic [n*MAX_BW-1:0] o_rd_data,
  output logic                o_ready,
  output logic                o_busy,
  output logic [ADDR_W:0]     o_wr_cnt,
  output logic                o_overflow
);

  localparam int unsigned LogN = $clog2(n);
  localparam int unsigned CntW = ADDR_W + 1;

  state_e          state_q, state_d;
  logic [CntW-1:0] exp_q, exp_d, wr_cnt_q, wr_cnt_d, exp_new;
  logic            ovf_q, ovf_d, busy_q, ready_q, rd_valid_q;
  logic [31:0]     exp_full;
  logic            clamp, wr_en, rd_ok;
  logic [ADDR_W-1:0] wr_addr;

  // Beats per table: 2^log2N / n, at least one, clamped to the store depth.
  always_comb begin
    exp_full = (32'(i_log2N) >= LogN) ? (32'd1 << (32'(i_log2N) - LogN)) : 32'd1;
    clamp    = exp_full > DEPTH;
    exp_new  = clamp ? CntW'(DEPTH) : CntW'(exp_full);
  end

  assign wr_en   = rst && i_valid && (i_start || state_q == StFill);
  assign wr_addr = i_start ? '0 : wr_cnt_q[ADDR_W-1:0];
  assign rd_ok   = i_rd_en && (state_q == StReady) && ({1'b0, i_rd_addr} < exp_q);

  always_comb begin
    state_d  = state_q;
    exp_d    = exp_q;
    wr_cnt_d = wr_cnt_q;
    ovf_d    = ovf_q;
    if (i_start) begin
      exp_d    = exp_new;
      ovf_d    = clamp;
      wr_cnt_d = i_valid ? CntW'(1) : '0;
      state_d  = (i_valid && exp_new == CntW'(1)) ? StReady : StFill;
    end else begin
      unique case (state_q)
        StFill: begin
          if (i_valid) begin
            wr_cnt_d = wr_cnt_q + 1'b1;
            if (wr_cnt_d == exp_q) state_d = StReady;
          end
        end
        StIdle, StReady: begin
          if (i_valid) ovf_d = 1'b1;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      exp_q      <= '0;
      wr_cnt_q   <= '0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      exp_q      <= exp_d;
      wr_cnt_q   <= wr_cnt_d;
      ovf_q      <= ovf_d;
      busy_q     <= (state_d == StFill);
      ready_q    <= (state_d == StReady);
      rd_valid_q <= rd_ok;
    end
  end

  tfg_buf_ram #(
    .Width(n * MAX_BW),
    .Depth(DEPTH),
    .AddrW(ADDR_W)
  ) u_ram (
    .clk_i    (clk),
    .rst_ni   (rst),
    .wr_en_i  (wr_en),
    .wr_addr_i(wr_addr),
    .wr_data_i(i_tfg),
    .rd_en_i  (rd_ok),
    .rd_addr_i(i_rd_addr),
    .rd_data_o(o_rd_data)
  );

  assign o_rd_valid = rd_valid_q;
  assign o_ready    = ready_q;
  assign o_busy     = busy_q;
  assign o_wr_cnt   = wr_cnt_q;
  assign o_overflow = ovf_q;

endmodule

// File: tb/tb_tfg_twiddle_store.sv
// Directed plus random checks of the twiddle store against a behavioural model.
module tb_tfg_twiddle_store;
  import tfg_pkg::*;

  localparam int unsigned Depth = 4;
  localparam int unsigned AddrW = 2;
  localparam int unsigned BW    = TfgLanes * TfgMaxBw;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             i_start = 1'b0;
  logic [3:0]       i_log2N = '0;
  logic             i_valid = 1'b0;
  logic [BW-1:0]    i_tfg = '0;
  logic             i_rd_en = 1'b0;
  logic [AddrW-1:0] i_rd_addr = '0;
  logic             o_rd_valid, o_ready, o_busy, o_overflow;
  logic [BW-1:0]    o_rd_data;
  logic [AddrW:0]   o_wr_cnt;

  tfg_twiddle_store #(.DEPTH(Depth)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_start   (i_start),
    .i_log2N   (i_log2N),
    .i_valid   (i_valid),
    .i_tfg     (i_tfg),
    .i_rd_en   (i_rd_en),
    .i_rd_addr (i_rd_addr),
    .o_rd_valid(o_rd_valid),
    .o_rd_data (o_rd_data),
    .o_ready   (o_ready),
    .o_busy    (o_busy),
    .o_wr_cnt  (o_wr_cnt),
    .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Behavioural model: table being filled / table complete / beats stored.
  bit            m_filling, m_complete, m_ovf, m_rdv;
  int            m_cnt, m_exp;
  logic [BW-1:0] m_rdd;
  logic [BW-1:0] m_mem [Depth];

  function automatic logic [BW-1:0] pattern_beat(input int b);
    logic [BW-1:0] r;
    for (int k = 0; k < TfgLanes; k++) r[k*TfgMaxBw +: TfgMaxBw] = TfgMaxBw'(100 * b + k);
    return r;
  endfunction

  function automatic logic [BW-1:0] rand_beat();
    logic [BW-1:0] r;
    for (int i = 0; i < BW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic model_step(input bit rs, input bit st, input int l2, input bit v,
                            input logic [BW-1:0] bt, input bit re, input int ra);
    int twiddles, e;
    if (!rs) begin
      m_filling = 0; m_complete = 0; m_cnt = 0; m_ovf = 0; m_rdv = 0; m_rdd = '0; m_exp = 0;
      return;
    end
    m_rdv = m_complete && re && (ra < m_exp);
    if (m_rdv) m_rdd = m_mem[ra];
    if (st) begin
      twiddles = 1 << l2;
      e = twiddles / TfgLanes;
      if (e < 1) e = 1;
      m_ovf = (e > Depth);
      m_exp = (e > Depth) ? Depth : e;
      m_cnt = 0; m_filling = 1; m_complete = 0;
      if (v) begin
        m_mem[0] = bt; m_cnt = 1;
      end
    end else if (m_filling) begin
      if (v) begin
        m_mem[m_cnt] = bt; m_cnt++;
      end
    end else if (v) begin
      m_ovf = 1;
    end
    if (m_filling && m_cnt == m_exp) begin
      m_filling = 0; m_complete = 1;
    end
  endtask

  task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs[63:0], exp[63:0]);
    end
  endtask

  task automatic cycle(input bit rs = 1, input bit st = 0, input int l2 = 0, input bit v = 0,
                       input logic [BW-1:0] bt = '0, input bit re = 0, input int ra = 0);
    rst = rs; i_start = st; i_log2N = 4'(l2); i_valid = v; i_tfg = bt;
    i_rd_en = re; i_rd_addr = AddrW'(ra);
    model_step(rs, st, l2, v, bt, re, ra);
    @(posedge clk);
    #1;
    check("ready", BW'(o_ready), BW'(m_complete));
    check("busy", BW'(o_busy), BW'(m_filling));
    check("wr_cnt", BW'(o_wr_cnt), BW'(m_cnt));
    check("overflow", BW'(o_overflow), BW'(m_ovf));
    check("rd_valid", BW'(o_rd_valid), BW'(m_rdv));
    check("rd_data", o_rd_data, m_rdd);
  endtask

  logic [BW-1:0] x_beat;

  initial begin
    // Reset
    cycle(.rs(0));
    cycle(.rs(0));
    // Basic fill: 32 twiddles -> 2 beats
    cycle(.st(1), .l2(5));
    cycle(.v(1), .bt(pattern_beat(0)));
    cycle(.v(1), .bt(pattern_beat(1)));
    check("basic_ready", BW'(o_ready), BW'(1));
    cycle(.re(1), .ra(0));
    check("basic_lane5", BW'(lane(o_rd_data, 5)), BW'(5));
    cycle(.re(1), .ra(1));
    check("basic_lane3", BW'(lane(o_rd_data, 3)), BW'(103));
    // Extra beat dropped, out-of-range read rejected
    cycle(.v(1), .bt(rand_beat()));
    cycle(.re(1), .ra(2));
    cycle(.re(1), .ra(0));
    check("reread_lane7", BW'(lane(o_rd_data, 7)), BW'(7));
    // Partial beat: 8 twiddles -> 1 beat
    cycle(.st(1), .l2(3));
    cycle(.v(1), .bt(pattern_beat(7)));
    cycle(.re(1), .ra(0));
    cycle(.re(1), .ra(1));
    // Start with beat on the same cycle and EXP==1
    cycle(.st(1), .l2(2), .v(1), .bt(pattern_beat(9)));
    cycle(.re(1), .ra(0));
    // Restart mid-fill: EXP=4
    cycle(.st(1), .l2(6));
    cycle(.v(1), .bt(rand_beat()));
    cycle(.v(1), .bt(rand_beat()));
    x_beat = rand_beat();
    cycle(.st(1), .l2(6), .v(1), .bt(x_beat));
    check("restart_cnt", BW'(o_wr_cnt), BW'(1));
    for (int i = 0; i < 3; i++) cycle(.v(1), .bt(pattern_beat(20 + i)));
    for (int a = 0; a < 4; a++) cycle(.re(1), .ra(a));
    // Size clamp: 128 twiddles -> 8 beats, clamped to 4
    cycle(.st(1), .l2(7));
    check("clamp_ovf", BW'(o_overflow), BW'(1));
    for (int i = 0; i < 4; i++) cycle(.v(1), .bt(rand_beat()));
    cycle(.re(1), .ra(3));
    // Reset mid-fill, then a beat while idle
    cycle(.st(1), .l2(6));
    cycle(.v(1), .bt(rand_beat()));
    cycle(.rs(0));
    cycle(.v(1), .bt(rand_beat()));
    check("idle_ovf", BW'(o_overflow), BW'(1));
    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cycle(.rs(($urandom_range(0, 63) != 0)), .st(($urandom_range(0, 11) == 0)),
            .l2($urandom_range(0, 15)), .v($urandom_range(0, 1) == 1), .bt(rand_beat()),
            .re($urandom_range(0, 1) == 1), .ra($urandom_range(0, 3)));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
